sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
- Request/response front-end that sits directly upstream of the team's 8x8 synchronous SRAM (the `sram` block).
- Accepts single-beat write requests and burst read requests over a valid/ready handshake.
- Sequences the SRAM's wr_en/addr/data pins and returns read data on a back-pressurable response channel.
- Hides the SRAM's registered read latency and its "read whenever not writing" behaviour from the requester.

Parameters:
- DW, 8, data width; must equal the SRAM data width.
- AW, 3, address width; SRAM depth is 2**AW (8).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  start address.
- req_wdata  input  DW  write data; ignored for reads.
- req_len  input  AW  read beats minus 1 (0..7 -> 1..8 beats); ignored for writes.
- resp_valid  output  1  read data beat present.
- resp_ready  input  1  consumer accepts beat.
- resp_rdata  output  DW  read data.
- resp_last  output  1  final beat of burst.
- mem_wr_en  output  1  to SRAM wr_en.
- mem_addr  output  AW  to SRAM addr.
- mem_wdata  output  DW  to SRAM data.
- mem_rdata  input  DW  from SRAM data_out.

Behaviour:
- SRAM contract:
  - Posedge with wr_en=1 writes data to mem[addr].
  - Posedge with wr_en=0 loads data_out <= mem[addr].
  - Same rst clears the array and data_out.
- All mem_* outputs are registered.
- Reset (rst=0 at posedge), from any state including mid-burst:
  - state=IDLE.
  - mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - resp_valid=0, resp_rdata=0, resp_last=0.
  - beat counter=0.
  - In-flight burst is dropped; no residual beats after reset.
- req_ready = (state==IDLE) && rst. Combinational from state, low during reset.
- Request accept: posedge with req_valid && req_ready. Request fields are sampled only at accept.
- FSM states:
  - IDLE: on write accept -> mem_addr<=req_addr, mem_wdata<=req_wdata, mem_wr_en<=1, go WR. On read accept -> mem_addr<=req_addr, remaining<=req_len, go RD_ADDR.
  - WR: mem_wr_en<=0, go IDLE. SRAM commits at this edge. Write occupies 2 cycles; req_ready returns 2 cycles after accept.
  - RD_ADDR: mem_addr stable, mem_wr_en=0; SRAM samples at this edge. Go RD_DATA.
  - RD_DATA: resp_rdata<=mem_rdata, resp_valid<=1, resp_last<=(remaining==0). Go RESP.
  - RESP: hold resp_valid/resp_rdata/resp_last stable until resp_ready.
    - On handshake with remaining==0: resp_valid<=0, go IDLE.
    - On handshake otherwise: resp_valid<=0, remaining<=remaining-1, mem_addr<=mem_addr+1 (mod 2**AW, wraps 7->0), go RD_ADDR.
- Latency:
  - Read accept at edge 0 -> resp_valid first high in cycle 3.
  - Each subsequent beat is high 3 cycles after the previous handshake. Throughput is 1 beat per 3 cycles when resp_ready is held high.
- Back-pressure: resp_ready low holds the beat indefinitely; mem_addr is unchanged while held.
- mem_wr_en is never high outside WR, so reads never corrupt the array.
- Write followed immediately by read to the same address returns the new data. The write commits at WR's edge, before RD_ADDR's sample.
- Requests arriving while busy are not accepted; the requester must hold them stable until req_ready.

Decomposition:
- Package sram_req_ctrl_pkg:
  - DW, AW, DEPTH=2**AW constants.
  - State enum {IDLE, WR, RD_ADDR, RD_DATA, RESP}.
- No sub-module. The FSM, address incrementer and beat counter sit in one block.
- The bench instantiates sram_req_ctrl wired to the sram block.

Test Plan:
- Write 0xA5 to addr 3, then read addr 3 len 0 -> req_ready low 2 cycles after each accept; resp_rdata=0xA5, resp_last=1, resp_valid in cycle 3 after read accept.
- Write 0x10..0x17 to addrs 0..7; burst read addr 6 len 3 -> beats 0x16, 0x17, 0x10, 0x11 (wrap); resp_last only on 4th beat.
- Same burst with resp_ready low 5 cycles on beat 2 -> 0x17 held stable, mem_addr=7 held, no beat lost or duplicated.
- After reset, read addr 5 -> 0x00; confirm mem_wr_en never asserts during the read.
- Assert rst=0 during beat 2 of an 8-beat burst -> next cycle resp_valid=0, req_ready=1 after rst=1; a new single read of addr 0 returns 0x00.
- req_valid held high with back-to-back write/read/write -> each accepted only when req_ready=1; no request dropped or double-accepted.

Source files
------------

// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants and FSM state type for the SRAM request front-end.
package sram_req_ctrl_pkg;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response handshake plus SRAM pin bundle between requester, controller and SRAM.
interface sram_req_ctrl_if
    import sram_req_ctrl_pkg::*;
#(
    parameter int DW = sram_req_ctrl_pkg::DW,
    parameter int AW = sram_req_ctrl_pkg::AW
);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [AW-1:0] req_len;

    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_last;

    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_len, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_last, mem_wr_en, mem_addr, mem_wdata
    );

    // Requester / memory side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_len, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_last, mem_wr_en, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram.sv
// 8x8 synchronous SRAM: registered read whenever not writing, synchronous active-low clear.
module sram #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] data_out
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // Array write or registered read; reset clears both array and output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
        end else if (wr_en) begin
            mem[addr] <= data;
        end else begin
            data_out <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Front-end sequencing single writes and burst reads onto the synchronous SRAM.
module sram_req_ctrl #(
    parameter int DW = sram_req_ctrl_pkg::DW,
    parameter int AW = sram_req_ctrl_pkg::AW
) (
    input  logic               clk,
    input  logic               rst,
    sram_req_ctrl_if.slave     bus
);

    import sram_req_ctrl_pkg::*;

    state_t        state_q,      state_d;
    logic          mem_wr_en_q,  mem_wr_en_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [DW-1:0] mem_wdata_q,  mem_wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;
    logic          resp_last_q,  resp_last_d;
    logic [AW-1:0] remaining_q,  remaining_d;

    logic req_ready;
    logic accept;

    // Ready only when idle and out of reset, so nothing is accepted on a reset edge.
    assign req_ready = (state_q == IDLE) && rst;
    assign accept    = bus.req_valid && req_ready;

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // Next-state and registered-output decode; write enable defaults low so it only pulses in WR.
    always_comb begin
        state_d      = state_q;
        mem_wr_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_last_d  = resp_last_q;
        remaining_d  = remaining_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr_d = bus.req_addr;
                    if (bus.req_we) begin
                        mem_wdata_d = bus.req_wdata;
                        mem_wr_en_d = 1'b1;
                        state_d     = WR;
                    end else begin
                        remaining_d = bus.req_len;
                        state_d     = RD_ADDR;
                    end
                end
            end
            WR: begin
                // SRAM commits the write on this edge.
                state_d = IDLE;
            end
            RD_ADDR: begin
                // SRAM registers mem[mem_addr] on this edge.
                state_d = RD_DATA;
            end
            RD_DATA: begin
                resp_rdata_d = bus.mem_rdata;
                resp_valid_d = 1'b1;
                resp_last_d  = (remaining_q == '0);
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = remaining_q - AW'(1);
                        mem_addr_d  = mem_addr_q + AW'(1);
                        state_d     = RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset dropping any burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_last_q  <= 1'b0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_last_q  <= resp_last_d;
            remaining_q  <= remaining_d;
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl wired to the sram block, with a transaction-level reference model.
module tb_sram_req_ctrl;

    logic clk;
    logic rst;

    sram_req_ctrl_if bus ();

    sram_req_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sram #(.DW(8), .AW(3)) u_sram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.mem_wr_en),
        .addr     (bus.mem_addr),
        .data     (bus.mem_wdata),
        .data_out (bus.mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic       last;
    } beat_t;

    logic [7:0] mm [8];
    beat_t      q [$];
    bit         m_busy  = 0;
    bit         m_wr    = 0;
    bit         m_valid = 0;
    int         m_timer = 0;
    bit         m_acc   = 0;
    bit         armed   = 0;

    // Transaction-level model: writes update the array at accept, reads queue their beats at accept.
    always @(posedge clk) begin
        bit hs, acc;
        m_acc = 0;
        if (!rst) begin
            for (int i = 0; i < 8; i++) mm[i] = 8'h00;
            q.delete();
            m_busy = 0; m_wr = 0; m_valid = 0; m_timer = 0;
            armed = 1;
        end else begin
            hs  = m_valid && bus.resp_ready;
            acc = bus.req_valid && !m_busy;
            if (m_wr) begin
                m_wr = 0;
                m_busy = 0;
            end else if (hs) begin
                void'(q.pop_front());
                m_valid = 0;
                if (q.size() == 0) m_busy = 0;
                else m_timer = 2;
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) m_valid = 1;
            end
            if (acc) begin
                m_acc  = 1;
                m_busy = 1;
                if (bus.req_we) begin
                    mm[bus.req_addr] = bus.req_wdata;
                    m_wr = 1;
                end else begin
                    for (int i = 0; i <= int'(bus.req_len); i++) begin
                        beat_t b;
                        b.a    = 3'(int'(bus.req_addr) + i);
                        b.d    = mm[b.a];
                        b.last = (i == int'(bus.req_len));
                        q.push_back(b);
                    end
                    m_timer = 2;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!m_busy && rst));
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_valid));
            chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(m_wr));
            if (m_valid && q.size() > 0) begin
                chk("resp_rdata", 32'(bus.resp_rdata), 32'(q[0].d));
                chk("resp_last", 32'(bus.resp_last), 32'(q[0].last));
                chk("mem_addr_hold", 32'(bus.mem_addr), 32'(q[0].a));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [2:0] a, input logic [7:0] d, input logic [2:0] len);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_len   = len;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 64);
        chk("req_accept", 32'(m_acc), 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_beat(input string nm, input logic [7:0] d, input logic last);
        int n = 0;
        while (!bus.resp_valid && n < 64) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus.resp_rdata), 32'(d));
        chk({nm, "_last"}, 32'(bus.resp_last), 32'(last));
        bus.resp_ready = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 200) begin
            tick();
            n++;
        end
        chk("drain_idle", 32'(m_busy), 32'd0);
    endtask

    bit rnd_done = 0;

    initial begin
        rst = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_len    = '0;
        bus.resp_ready = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Write A5 to 3, then single read of 3 with exact latency.
        do_req(1'b1, 3'd3, 8'hA5, 3'd0);
        chk("wr_busy", 32'(bus.req_ready), 32'd0);
        tick();
        chk("wr_ready_back", 32'(bus.req_ready), 32'd1);
        bus.resp_ready = 1'b1;
        do_req(1'b0, 3'd3, 8'h00, 3'd0);
        chk("rd_lat0", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("rd_lat1", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("rd_lat2", 32'(bus.resp_valid), 32'd1);
        chk("rd_a5", 32'(bus.resp_rdata), 32'hA5);
        chk("rd_a5_last", 32'(bus.resp_last), 32'd1);
        tick();

        // Fill 0x10..0x17, then wrapping burst.
        for (int i = 0; i < 8; i++) do_req(1'b1, 3'(i), 8'(8'h10 + i), 3'd0);
        tick();
        do_req(1'b0, 3'd6, 8'h00, 3'd3);
        wait_beat("burst_b0", 8'h16, 1'b0);
        wait_beat("burst_b1", 8'h17, 1'b0);
        wait_beat("burst_b2", 8'h10, 1'b0);
        wait_beat("burst_b3", 8'h11, 1'b1);
        wait_idle();

        // Same burst with back-pressure on beat 2.
        do_req(1'b0, 3'd6, 8'h00, 3'd3);
        wait_beat("bp_b0", 8'h16, 1'b0);
        bus.resp_ready = 1'b0;
        for (int n = 0; n < 64 && !bus.resp_valid; n++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", 32'(bus.resp_rdata), 32'h17);
            chk("bp_hold_addr", 32'(bus.mem_addr), 32'd7);
            chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            tick();
        end
        wait_beat("bp_b1", 8'h17, 1'b0);
        wait_beat("bp_b2", 8'h10, 1'b0);
        wait_beat("bp_b3", 8'h11, 1'b1);
        wait_idle();

        // Reset clears the array.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        do_req(1'b0, 3'd5, 8'h00, 3'd0);
        wait_beat("rst_rd5", 8'h00, 1'b1);
        wait_idle();

        // Reset in the middle of an 8-beat burst.
        do_req(1'b1, 3'd0, 8'h55, 3'd0);
        tick();
        do_req(1'b0, 3'd0, 8'h00, 3'd7);
        wait_beat("mid_b0", 8'h55, 1'b0);
        bus.resp_ready = 1'b0;
        for (int n = 0; n < 64 && !bus.resp_valid; n++) tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(bus.req_ready), 32'd1);
        repeat (4) tick();
        bus.resp_ready = 1'b1;
        do_req(1'b0, 3'd0, 8'h00, 3'd0);
        wait_beat("mid_rd0", 8'h00, 1'b1);
        wait_idle();

        // Back-to-back write/read/write with req_valid held high.
        bus.resp_ready = 1'b1;
        do_req(1'b1, 3'd2, 8'h3C, 3'd0);
        bus.req_valid = 1'b1;
        do_req(1'b0, 3'd2, 8'h00, 3'd0);
        bus.req_valid = 1'b1;
        do_req(1'b1, 3'd2, 8'hC3, 3'd0);
        wait_idle();
        do_req(1'b0, 3'd2, 8'h00, 3'd0);
        wait_beat("b2b_rd", 8'hC3, 1'b1);
        wait_idle();

        // Randomized traffic with random back-pressure and occasional reset.
        fork
            begin
                while (!rnd_done) begin
                    bus.resp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
            begin
                for (int t = 0; t < 200; t++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    if ($urandom_range(0, 49) == 0) begin
                        rst = 1'b0;
                        tick();
                        rst = 1'b1;
                    end
                    do_req(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 3'($urandom));
                end
                rnd_done = 1;
            end
        join
        bus.resp_ready = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
